nios2_debug_monitor_mem: RTL

Debug monitor memory engine for the Nios II on-chip debug path. Consumes the system-clock-domain `jdo` word and the single-cycle `take_action_ocimem_*` / `take_no_action_ocimem_a` strobes from the debug slave, and executes JTAG reads and writes into a word-addressed monitor RAM. Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for scan-out. Also exposes the RAM to the CPU over an Avalon-MM slave, with JTAG given priority.

---
 rtl/debug_mon_pkg.sv | 23 ++
 rtl/debug_monitor_ram.sv | 29 ++
 rtl/nios2_debug_monitor_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/debug_mon_pkg.sv
// Shared types and jdo field positions for the Nios II debug monitor memory engine.
package debug_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StJrd,
    StJcap,
    StJwr,
    StCrd
  } mon_state_e;

  typedef enum logic [1:0] {
    CmdNone,
    CmdRead,
    CmdWrite
  } mon_cmd_e;

  localparam int unsigned JDO_CLR_ERR_BIT = 35;
  localparam int unsigned JDO_RD_BIT      = 34;
  localparam int unsigned JDO_ADDR_LSB    = 17;
  localparam int unsigned JDO_DATA_LSB    = 3;

endpackage

// File: rtl/debug_monitor_ram.sv
// Single-port 2^AW x 32 synchronous RAM with byte enables and one cycle of read latency.
module debug_monitor_ram #(
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nios2_debug_monitor_mem.sv
// JTAG debug monitor memory engine with an optional CPU Avalon-MM port (JTAG has priority).
// The CPU port is arbitrated only when DEBUG_MON_CPU_PORT_EN is defined; otherwise it is ignored.
module nios2_debug_monitor_mem
  import debug_mon_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_writedata,
  input  logic [3:0]    cpu_byteenable,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_waitrequest,
  output logic [31:0]   MonDReg,
  output logic [AW-1:0] MonAReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  mon_state_e    state_q, state_d;
  mon_cmd_e      pend_kind_q, pend_kind_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic [AW-1:0] mon_a_q, mon_a_d;
  logic [31:0]   mon_d_q, mon_d_d;
  logic          mon_rdy_q, mon_rdy_d;
  logic          mon_err_q, mon_err_d;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic cpu_rd, cpu_wr, cpu_wr_grant;
  logic busy, drop;
  logic unused_sig;

`ifdef DEBUG_MON_CPU_PORT_EN
  assign cpu_rd          = cpu_read;
  assign cpu_wr          = cpu_write;
  assign cpu_waitrequest = !reset_n || (cpu_wr && !cpu_wr_grant) ||
                           (cpu_rd && (state_q != StCrd));
  assign cpu_readdata    = (state_q == StCrd) ? ram_rdata : '0;
  assign unused_sig      = ^{jdo[2:0], jdo[37:36]};
`else
  assign cpu_rd          = 1'b0;
  assign cpu_wr          = 1'b0;
  assign cpu_waitrequest = 1'b0;
  assign cpu_readdata    = '0;
  assign unused_sig      = ^{jdo[2:0], jdo[37:36], cpu_read, cpu_write};
`endif

  assign busy = (pend_kind_q != CmdNone);
  // A pending JTAG command blocks CPU writes even in IDLE.
  assign cpu_wr_grant = cpu_wr && reset_n && (state_q == StIdle) && !busy;

  always_comb begin
    state_d     = state_q;
    pend_kind_d = pend_kind_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    mon_rdy_d   = mon_rdy_q;
    mon_err_d   = mon_err_q;
    ram_addr    = cpu_address;
    ram_we      = 1'b0;
    ram_be      = cpu_byteenable;
    ram_wdata   = cpu_writedata;
    drop        = 1'b0;

    // Strobe acceptance: b > a > no_action; every loser or overrun is dropped.
    if (take_action_ocimem_b) begin
      drop = busy || take_action_ocimem_a || take_no_action_ocimem_a;
      if (!busy) begin
        pend_kind_d = CmdWrite;
        pend_addr_d = mon_a_q;
        pend_data_d = jdo[JDO_DATA_LSB +: 32];
        mon_rdy_d   = 1'b0;
      end
    end else if (take_action_ocimem_a) begin
      drop = busy || take_no_action_ocimem_a;
      if (!busy) begin
        mon_a_d   = jdo[JDO_ADDR_LSB +: AW];
        mon_rdy_d = 1'b0;
        if (jdo[JDO_CLR_ERR_BIT]) begin
          mon_err_d = 1'b0;
        end
        if (jdo[JDO_RD_BIT]) begin
          pend_kind_d = CmdRead;
          pend_addr_d = jdo[JDO_ADDR_LSB +: AW];
        end
      end
    end else if (take_no_action_ocimem_a) begin
      drop = busy;
      if (!busy) begin
        pend_kind_d = CmdRead;
        pend_addr_d = mon_a_q;
        mon_rdy_d   = 1'b0;
      end
    end
    if (drop) begin
      mon_err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_wr_grant) begin
          ram_we = 1'b1;
        end
        if (pend_kind_d == CmdRead) begin
          state_d = StJrd;
        end else if (pend_kind_d == CmdWrite) begin
          state_d = StJwr;
        end else if (cpu_rd && !cpu_wr_grant) begin
          state_d = StCrd;
        end
      end
      StJrd: begin
        ram_addr = pend_addr_q;
        state_d  = StJcap;
      end
      StJcap: begin
        mon_d_d     = ram_rdata;
        mon_a_d     = mon_a_q + AW'(1);
        mon_rdy_d   = 1'b1;
        pend_kind_d = CmdNone;
        state_d     = StIdle;
      end
      StJwr: begin
        ram_addr    = pend_addr_q;
        ram_we      = 1'b1;
        ram_be      = 4'hF;
        ram_wdata   = pend_data_q;
        mon_a_d     = mon_a_q + AW'(1);
        mon_rdy_d   = 1'b1;
        pend_kind_d = CmdNone;
        state_d     = StIdle;
      end
      StCrd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pend_kind_q <= CmdNone;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      mon_rdy_q   <= 1'b0;
      mon_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      mon_rdy_q   <= mon_rdy_d;
      mon_err_q   <= mon_err_d;
    end
  end

  // RAM write enable is not gated by reset so a write already in JWR still lands.
  debug_monitor_ram #(
    .AW(AW)
  ) u_ram (
    .clk_i  (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign MonDReg       = mon_d_q;
  assign MonAReg       = mon_a_q;
  assign monitor_ready = mon_rdy_q;
  assign monitor_error = mon_err_q;

endmodule
